// File: rtl/ghost_pkg.sv
// Shared ghost-controller types: mode encoding, internal state encoding and default frame counts.
package ghost_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_SCATTER = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_FRIGHT  = 2'b11
  } ghost_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCATTER = 3'd1,
    ST_CHASE   = 3'd2,
    ST_FRIGHT  = 3'd3,
    ST_CAUGHT  = 3'd4
  } ghost_state_e;

  localparam int DEF_SCATTER_FRAMES = 420;
  localparam int DEF_CHASE_FRAMES   = 1200;
  localparam int DEF_FRIGHT_FRAMES  = 360;
  localparam int DEF_NUM_PHASES     = 7;

  localparam int PHASE_W      = 16;
  localparam int FRIGHT_W     = 10;
  localparam int FLASH_START  = 120;
  localparam int FLASH_PERIOD = 15;

  // CAUGHT reports the IDLE encoding: ghosts are frozen, not hunting.
  function automatic ghost_mode_e state_to_mode(input ghost_state_e st);
    ghost_mode_e m;
    m = MODE_IDLE;
    case (st)
      ST_SCATTER: m = MODE_SCATTER;
      ST_CHASE:   m = MODE_CHASE;
      ST_FRIGHT:  m = MODE_FRIGHT;
      default:    m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter; load wins over enable and the count holds once it reaches zero.
module frame_timer
  import ghost_pkg::*;
#(
  parameter int WIDTH = FRIGHT_W
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost scatter/chase/frightened sequencer with one phase timer and one fright timer.
// Optional flash output when GHOST_MODE_FLASH_EN is defined.
//
// state   | meaning
// IDLE    | waiting for game start, ghosts frozen
// SCATTER | ghosts head for their corners, phase timer running
// CHASE   | ghosts hunt pac-man, phase timer running (frozen once phases exhausted)
// FRIGHT  | power pellet active, phase timer frozen, fright timer running
// CAUGHT  | pac-man caught, ghosts frozen until next start
module ghost_mode_ctrl
  import ghost_pkg::*;
#(
  parameter int SCATTER_FRAMES = DEF_SCATTER_FRAMES,
  parameter int CHASE_FRAMES   = DEF_CHASE_FRAMES,
  parameter int FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
  parameter int NUM_PHASES     = DEF_NUM_PHASES
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       pellet,
  input  logic       collide,
  output logic [1:0] mode,
  output logic       reverse,
  output logic       stop,
  output logic [2:0] phase_idx,
  output logic [9:0] fright_left
`ifdef GHOST_MODE_FLASH_EN
  ,
  output logic       flash
`endif
);

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES);

  ghost_state_e state_q, state_d;
  ghost_state_e saved_q, saved_d;
  ghost_state_e next_st;
  ghost_mode_e  mode_q, mode_d;
  logic [2:0]   phase_idx_q, phase_idx_d, next_idx;
  logic         stop_q, stop_d;
  logic         reverse_q, reverse_d;

  logic                ph_load, ph_en, ph_zero;
  logic [PHASE_W-1:0]  ph_val, ph_value;
  logic                fr_load, fr_en, fr_zero;
  logic [FRIGHT_W-1:0] fr_value;
  logic                unused_ph_value;

  frame_timer #(.WIDTH(PHASE_W)) u_phase_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (ph_load),
    .load_val  (ph_val),
    .en        (ph_en),
    .value     (ph_value),
    .zero      (ph_zero)
  );

  frame_timer #(.WIDTH(FRIGHT_W)) u_fright_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (fr_load),
    .load_val  (FRIGHT_W'(FRIGHT_FRAMES - 1)),
    .en        (fr_en),
    .value     (fr_value),
    .zero      (fr_zero)
  );

  assign unused_ph_value = ^ph_value;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    phase_idx_d = phase_idx_q;
    reverse_d   = 1'b0;
    ph_load     = 1'b0;
    ph_val      = '0;
    ph_en       = 1'b0;
    fr_load     = 1'b0;
    fr_en       = 1'b0;
    next_idx    = phase_idx_q + 3'd1;
    // The final phase always lands in CHASE, whatever parity NUM_PHASES has.
    next_st     = ((state_q == ST_SCATTER) || (next_idx == LAST_PHASE)) ? ST_CHASE : ST_SCATTER;

    case (state_q)
      ST_IDLE, ST_CAUGHT: begin
        if (start) begin
          state_d     = ST_SCATTER;
          phase_idx_d = '0;
          ph_load     = 1'b1;
          ph_val      = PHASE_W'(SCATTER_FRAMES - 1);
        end
      end
      ST_SCATTER, ST_CHASE: begin
        if (collide) begin
          state_d = ST_CAUGHT;
        end else if (pellet) begin
          state_d   = ST_FRIGHT;
          saved_d   = state_q;
          fr_load   = 1'b1;
          reverse_d = 1'b1;
        end else if (phase_idx_q == LAST_PHASE) begin
          state_d = ST_CHASE;
        end else if (ph_zero) begin
          state_d     = next_st;
          phase_idx_d = next_idx;
          ph_load     = 1'b1;
          ph_val      = (next_st == ST_SCATTER) ? PHASE_W'(SCATTER_FRAMES - 1)
                                                : PHASE_W'(CHASE_FRAMES - 1);
          reverse_d   = (next_st != state_q);
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_FRIGHT: begin
        if (pellet) begin
          fr_load = 1'b1;
        end else if (fr_zero) begin
          state_d = saved_q;
        end else begin
          fr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mode_d = state_to_mode(state_d);
    stop_d = (state_d == ST_IDLE) || (state_d == ST_CAUGHT);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      saved_q     <= ST_IDLE;
      phase_idx_q <= '0;
      mode_q      <= MODE_IDLE;
      stop_q      <= 1'b1;
      reverse_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      phase_idx_q <= phase_idx_d;
      mode_q      <= mode_d;
      stop_q      <= stop_d;
      reverse_q   <= reverse_d;
    end
  end

  assign mode        = mode_q;
  assign stop        = stop_q;
  assign reverse     = reverse_q;
  assign phase_idx   = phase_idx_q;
  assign fright_left = (state_q == ST_FRIGHT) ? fr_value : '0;

`ifdef GHOST_MODE_FLASH_EN
  logic [FRIGHT_W-1:0] flash_elapsed;
  logic [FRIGHT_W-1:0] flash_slot;

  // Even 15-frame slots after the warning threshold are lit, so flashing starts high.
  always_comb begin
    flash_elapsed = FRIGHT_W'(FLASH_START - 1) - fr_value;
    flash_slot    = flash_elapsed / FRIGHT_W'(FLASH_PERIOD);
    flash         = (state_q == ST_FRIGHT) && (fr_value < FRIGHT_W'(FLASH_START)) &&
                    ((flash_slot & FRIGHT_W'(1)) == '0);
  end
`endif

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed self-checking bench for ghost_mode_ctrl; a second small-parameter instance covers phase exhaustion.
module tb_ghost_mode_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic       start, pellet, collide;
  logic [1:0] mode;
  logic       reverse, stop;
  logic [2:0] phase_idx;
  logic [9:0] fright_left;
`ifdef GHOST_MODE_FLASH_EN
  logic       flash;
  logic       s_flash;
`endif

  logic       s_start, s_pellet, s_collide;
  logic [1:0] s_mode;
  logic       s_reverse, s_stop;
  logic [2:0] s_phase_idx;
  logic [9:0] s_fright_left;

  int checks;
  int errors;
  int rev_cnt;
  int first7;

  ghost_mode_ctrl u_dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .start       (start),
    .pellet      (pellet),
    .collide     (collide),
    .mode        (mode),
    .reverse     (reverse),
    .stop        (stop),
    .phase_idx   (phase_idx),
    .fright_left (fright_left)
`ifdef GHOST_MODE_FLASH_EN
    ,
    .flash       (flash)
`endif
  );

  ghost_mode_ctrl #(
    .SCATTER_FRAMES (4),
    .CHASE_FRAMES   (6),
    .FRIGHT_FRAMES  (360),
    .NUM_PHASES     (7)
  ) u_small (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .start       (s_start),
    .pellet      (s_pellet),
    .collide     (s_collide),
    .mode        (s_mode),
    .reverse     (s_reverse),
    .stop        (s_stop),
    .phase_idx   (s_phase_idx),
    .fright_left (s_fright_left)
`ifdef GHOST_MODE_FLASH_EN
    ,
    .flash       (s_flash)
`endif
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    start     = 1'b0;
    pellet    = 1'b0;
    collide   = 1'b0;
    s_start   = 1'b0;
    s_pellet  = 1'b0;
    s_collide = 1'b0;
    #12;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_stop", 32'(stop), 32'd1);
    check("rst_reverse", 32'(reverse), 32'd0);
    check("rst_phase_idx", 32'(phase_idx), 32'd0);
    check("rst_fright_left", 32'(fright_left), 32'd0);
    check("rst_small_stop", 32'(s_stop), 32'd1);
    Reset = 1'b0;

    tick();
    check("idle_mode", 32'(mode), 32'd0);
    pellet = 1'b1; tick(); pellet = 1'b0;
    check("idle_pellet_mode", 32'(mode), 32'd0);
    check("idle_pellet_rev", 32'(reverse), 32'd0);

    // Small instance: S4 C6 S4 C6 S4 C6 S4 then permanent chase at tick 34.
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("small_start_mode", 32'(s_mode), 32'd1);
    rev_cnt = 0;
    first7  = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (s_reverse) rev_cnt++;
      if (s_phase_idx == 3'd7 && first7 == 0) first7 = t;
    end
    check("small_rev_count", 32'(rev_cnt), 32'd7);
    check("small_phase7_tick", 32'(first7), 32'd34);
    check("small_final_mode", 32'(s_mode), 32'd2);
    check("small_final_idx", 32'(s_phase_idx), 32'd7);
    check("small_final_rev", 32'(s_reverse), 32'd0);
    check("small_fright_left", 32'(s_fright_left), 32'd0);

    // Start, 420-frame scatter, then chase with a reverse pulse.
    start = 1'b1; tick(); start = 1'b0;
    check("start_mode", 32'(mode), 32'd1);
    check("start_stop", 32'(stop), 32'd0);
    check("start_rev", 32'(reverse), 32'd0);
    check("start_idx", 32'(phase_idx), 32'd0);
    run(419);
    check("scatter_end_mode", 32'(mode), 32'd1);
    check("scatter_end_rev", 32'(reverse), 32'd0);
    tick();
    check("chase_mode", 32'(mode), 32'd2);
    check("chase_rev", 32'(reverse), 32'd1);
    check("chase_idx", 32'(phase_idx), 32'd1);
    tick();
    check("chase_rev_off", 32'(reverse), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("chase_start_ign_mode", 32'(mode), 32'd2);
    check("chase_start_ign_idx", 32'(phase_idx), 32'd1);

    // Collide beats pellet.
    collide = 1'b1; pellet = 1'b1; tick(); collide = 1'b0; pellet = 1'b0;
    check("caught_mode", 32'(mode), 32'd0);
    check("caught_stop", 32'(stop), 32'd1);
    check("caught_rev", 32'(reverse), 32'd0);
    pellet = 1'b1; tick(); pellet = 1'b0;
    check("caught_pellet_mode", 32'(mode), 32'd0);

    // Restart, pellet at scatter count 100.
    start = 1'b1; tick(); start = 1'b0;
    check("restart_mode", 32'(mode), 32'd1);
    check("restart_idx", 32'(phase_idx), 32'd0);
    check("restart_stop", 32'(stop), 32'd0);
    run(319);
    pellet = 1'b1; tick(); pellet = 1'b0;
    check("fright_mode", 32'(mode), 32'd3);
    check("fright_rev", 32'(reverse), 32'd1);
    check("fright_left_359", 32'(fright_left), 32'd359);
    run(359);
    check("fright_last_left", 32'(fright_left), 32'd0);
    check("fright_last_mode", 32'(mode), 32'd3);
    tick();
    check("fright_exit_mode", 32'(mode), 32'd1);
    check("fright_exit_rev", 32'(reverse), 32'd0);
    check("fright_exit_left", 32'(fright_left), 32'd0);
    run(100);
    check("resume_end_mode", 32'(mode), 32'd1);
    tick();
    check("resume_toggle_mode", 32'(mode), 32'd2);
    check("resume_toggle_rev", 32'(reverse), 32'd1);
    check("resume_toggle_idx", 32'(phase_idx), 32'd1);

    // Fright from chase, collide ignored, reload at 10.
    pellet = 1'b1; tick(); pellet = 1'b0;
    check("fright2_mode", 32'(mode), 32'd3);
    check("fright2_rev", 32'(reverse), 32'd1);
    collide = 1'b1; tick(); collide = 1'b0;
    check("fright_collide_mode", 32'(mode), 32'd3);
    check("fright_collide_stop", 32'(stop), 32'd0);
    check("fright_collide_left", 32'(fright_left), 32'd358);
    run(348);
    check("fright_left_10", 32'(fright_left), 32'd10);
    pellet = 1'b1; tick(); pellet = 1'b0;
    check("reload_left", 32'(fright_left), 32'd359);
    check("reload_rev", 32'(reverse), 32'd0);
    check("reload_mode", 32'(mode), 32'd3);
    tick();
    check("reload_next_left", 32'(fright_left), 32'd358);
    run(238);
    check("left_120", 32'(fright_left), 32'd120);
`ifdef GHOST_MODE_FLASH_EN
    check("flash_120", 32'(flash), 32'd0);
`endif
    tick();
`ifdef GHOST_MODE_FLASH_EN
    check("flash_119", 32'(flash), 32'd1);
`endif
    run(14);
    check("left_105", 32'(fright_left), 32'd105);
`ifdef GHOST_MODE_FLASH_EN
    check("flash_105", 32'(flash), 32'd1);
`endif
    tick();
`ifdef GHOST_MODE_FLASH_EN
    check("flash_104", 32'(flash), 32'd0);
`endif
    run(14);
`ifdef GHOST_MODE_FLASH_EN
    check("flash_90", 32'(flash), 32'd0);
`endif
    tick();
    check("left_89", 32'(fright_left), 32'd89);
`ifdef GHOST_MODE_FLASH_EN
    check("flash_89", 32'(flash), 32'd1);
`endif

    // Asynchronous reset mid-fright.
    Reset = 1'b1;
    #1;
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_stop", 32'(stop), 32'd1);
    check("midrst_left", 32'(fright_left), 32'd0);
    check("midrst_rev", 32'(reverse), 32'd0);
    check("midrst_idx", 32'(phase_idx), 32'd0);
`ifdef GHOST_MODE_FLASH_EN
    check("midrst_flash", 32'(flash), 32'd0);
`endif
    Reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("post_rst_mode", 32'(mode), 32'd1);
    check("post_rst_idx", 32'(phase_idx), 32'd0);
    run(419);
    check("post_rst_scatter", 32'(mode), 32'd1);
    tick();
    check("post_rst_chase", 32'(mode), 32'd2);
    check("post_rst_rev", 32'(reverse), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
